pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL: parameter DATA_W, 32, payload width in bits.
REQ-002 SHALL: parameter CTRL_W, 8, width of the control field in payload bits [CTRL_W-1:0]; legal range 1..DATA_W.
REQ-003 SHALL: parameter CNT_W, 16, stall counter width.
REQ-004 SHALL: Clock  in  1  single clock, all state updates on its rising edge.
REQ-005 SHALL: Reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL: in_valid  in  1  upstream offers a payload.
REQ-007 SHALL: in_ready  out  1  stage accepts the payload this cycle.
REQ-008 SHALL: in_data  in  DATA_W  upstream payload.
REQ-009 SHALL: Stall  in  1  hold request from hazard logic; treated as out_ready=0.
REQ-010 SHALL: Flush  in  1  squash all held payloads (branch or exception kill).
REQ-011 SHALL: out_valid  out  1  downstream payload valid.
REQ-012 SHALL: out_ready  in  1  downstream accepts.
REQ-013 SHALL: out_data  out  DATA_W  downstream payload.
REQ-014 SHALL: stall_count  out  CNT_W  saturating count of held cycles.

Function
REQ-015 SHALL: input transfer occurs on an edge where in_valid && in_ready; output transfer occurs where out_valid && out_ready && !Stall.
REQ-016 SHALL: payloads leave in acceptance order; none is duplicated or dropped except by Flush.
REQ-017 SHALL: main register (out_valid/out_data) loads in_data one cycle after acceptance when empty or draining; latency in->out is 1 cycle.
REQ-018 SHALL: while out_valid=0, out_data[CTRL_W-1:0] reads 0 (bubble: all control bits deasserted); bits above CTRL_W-1 retain last loaded value.
REQ-019 SHALL: Flush at an edge clears out_valid and all skid state; in_ready is 0 while Flush is high, so a simultaneous in_valid is dropped.
REQ-020 SHALL: Flush dominates Stall and out_ready; a payload presented at out_* in a Flush cycle is not counted as transferred by this block.
REQ-021 SHALL: stall_count increments by 1 each edge with out_valid=1 and no output transfer, and saturates at all-ones.
REQ-022 SHALL: stall_count is not cleared by Flush.
REQ-023 SHALL: simultaneous input and output transfer with a single held payload leaves out_valid=1 carrying the new payload (full throughput, no bubble).

Reset
REQ-024 SHALL: Reset asserted forces out_valid=0, out_data=0, skid state empty and stall_count=0 immediately, independent of Clock.
REQ-025 SHALL: in_ready is 0 while Reset is high; first acceptance is possible on the first edge after Reset deasserts.
REQ-026 SHALL: Reset mid-transfer discards all held payloads without emitting a partial or stale out_valid.

Configuration
REQ-027 SHALL: macro PIPE_STAGE_SKID_EN selects the ready path.
REQ-028 SHALL: with PIPE_STAGE_SKID_EN undefined, in_ready = !Flush && !Stall && (out_ready || !out_valid) combinationally; no skid storage exists.
REQ-029 SHALL: with PIPE_STAGE_SKID_EN defined, a one-entry skid register is added and in_ready = !skid_valid && !Flush && !Reset, with no combinational path from out_ready or Stall to in_ready.
REQ-030 SHALL: in skid mode, a payload accepted while the main register holds and cannot drain goes to skid; on the next output transfer, skid moves to main in that same edge and skid_valid clears.
REQ-031 SHALL: in skid mode, with skid full and main held, in_ready=0 and both payloads are held unchanged.

Verification
REQ-032 SHALL: stream 0x11,0x22,0x33 back-to-back, out_ready=1 -> same values on out_data on cycles 1,2,3 after acceptance, out_valid continuous.
REQ-033 SHALL: out_valid=1 holding 0xA5, out_ready=0 for 4 cycles -> out_data stable at 0xA5, stall_count=4.
REQ-034 SHALL: skid build, offer 0x1,0x2,0x3 with out_ready=0 -> accepts 0x1,0x2, in_ready=0 for 0x3; release out_ready -> outputs 0x1,0x2,0x3 in order.
REQ-035 SHALL: Flush with main and skid full and in_valid=1 -> next cycle out_valid=0, out_data[7:0]=0, offered payload lost, stall_count unchanged.
REQ-036 SHALL: hold stall condition 2^CNT_W+5 cycles -> stall_count saturates at all-ones; assert Reset mid-hold -> all outputs 0 before next Clock edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, stall and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that registers the ready path.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              Stall,
  input  logic              Flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_count
);

  // Low CTRL_W bits are control; they must read as a bubble whenever the stage is empty.
  localparam logic [DATA_W-1:0] CTRL_MASK = {DATA_W{1'b1}} >> (DATA_W - CTRL_W);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              out_fire;
  logic              in_fire;

  assign out_fire  = main_valid && out_ready && !Stall && !Flush;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : (main_data & ~CTRL_MASK);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      stall_count <= '0;
    else if (main_valid && !out_fire && !Flush && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + CNT_W'(1);
  end

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              drain;

  // Ready depends only on registered skid state, breaking the out_ready/Stall timing path.
  assign in_ready = !skid_valid && !Flush && !Reset;
  assign drain    = !main_valid || out_fire;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (Flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
`else
  assign in_ready = !Flush && !Stall && !Reset && (out_ready || !main_valid);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
    end else if (Flush) begin
      main_valid <= 1'b0;
    end else if (in_fire) begin
      main_valid <= 1'b1;
      main_data  <= in_data;
    end else if (out_fire) begin
      main_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver pushes accepted payloads, monitor checks order,
// bubble control bits, ready and the saturating stall counter against a queue model.
module tb_pipe_stage_reg;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              in_valid = 1'b0, in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              Stall = 1'b0, Flush = 1'b0;
  logic              out_valid, out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_count;

  int checks = 0, errors = 0;
  logic [DATA_W-1:0] q[$];
  int  cnt_m = 0;
  bit  done = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .Stall(Stall), .Flush(Flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .stall_count(stall_count)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: mid low phase, inputs for the coming edge are stable.
  initial begin
    forever begin
      @(negedge Clock); #2;
      if (done) break;
      if (Reset) begin
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_stall_count", 64'(stall_count), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        q.delete();
        cnt_m = 0;
      end else begin
        if (CAP == 2)
          chk("in_ready", 64'(in_ready), 64'(q.size() < 2 && !Flush));
        else
          chk("in_ready", 64'(in_ready), 64'(!Flush && !Stall && (q.size() == 0 || out_ready)));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) chk("out_data", 64'(out_data), 64'(q[0]));
        else              chk("bubble_ctrl", 64'(out_data[CTRL_W-1:0]), 64'(0));
        chk("stall_count", 64'(stall_count), 64'(cnt_m));
        if (Flush) q.delete();
        else if (q.size() > 0 && out_ready && !Stall) void'(q.pop_front());
        else if (q.size() > 0 && cnt_m < CNT_MAX) cnt_m++;
      end
    end
  end

  task automatic cyc(input bit v, input logic [DATA_W-1:0] d, input bit ordy,
                     input bit st, input bit fl, input bit rs);
    @(negedge Clock);
    Reset = rs; in_valid = v; in_data = d; out_ready = ordy; Stall = st; Flush = fl;
    #3;
    if (v && in_ready && !Reset) q.push_back(d);
  endtask

  task automatic offer(input logic [DATA_W-1:0] d, input bit ordy);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = in_ready && !Reset;
      cyc(1, d, ordy, 0, 0, 0);
      ok = (in_ready == 1'b1);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL offer_timeout actual=not_accepted expected=accepted data=%0h", d);
    end
  endtask

  initial begin
    repeat (2) cyc(0, '0, 0, 0, 0, 1);
    // back-to-back stream with full throughput
    cyc(1, 32'h11, 1, 0, 0, 0);
    cyc(1, 32'h22, 1, 0, 0, 0);
    cyc(1, 32'h33, 1, 0, 0, 0);
    repeat (2) cyc(0, '0, 1, 0, 0, 0);
    // hold 0xA5 for four edges
    cyc(1, 32'hA5, 0, 0, 0, 0);
    repeat (4) cyc(0, '0, 0, 0, 0, 0);
    @(negedge Clock); #1;
    chk("hold_stall4", 64'(stall_count), 64'(4));
    chk("hold_data", 64'(out_data), 64'(32'hA5));
    cyc(0, '0, 1, 0, 0, 0);
    // skid build then release
    cyc(1, 32'h1, 0, 0, 0, 0);
    cyc(1, 32'h2, 0, 0, 0, 0);
    cyc(1, 32'h3, 0, 0, 0, 0);
    offer(32'h3, 1);
    repeat (4) cyc(0, '0, 1, 0, 0, 0);
    // flush with stage full and a payload offered
    cyc(1, 32'hB1, 0, 0, 0, 0);
    cyc(1, 32'hB2, 0, 0, 0, 0);
    cyc(1, 32'hC3, 0, 0, 1, 0);
    @(negedge Clock); #1;
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_ctrl", 64'(out_data[7:0]), 64'(0));
    chk("flush_cnt", 64'(stall_count), 64'(cnt_m));
    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 1) == 1, $urandom, ($urandom % 4) != 0,
          ($urandom % 8) == 0, ($urandom % 16) == 0, 0);
    cyc(0, '0, 1, 0, 1, 0);
    // saturation under Stall, then asynchronous reset mid-hold
    cyc(1, 32'h5A, 0, 0, 0, 0);
    repeat ((1 << CNT_W) + 5) cyc(0, '0, 1, 1, 0, 0);
    @(negedge Clock); #1;
    chk("sat_cnt", 64'(stall_count), 64'(CNT_MAX));
    @(posedge Clock); #2;
    Reset = 1'b1;
    #1;
    chk("async_valid", 64'(out_valid), 64'(0));
    chk("async_data", 64'(out_data), 64'(0));
    chk("async_cnt", 64'(stall_count), 64'(0));
    chk("async_ready", 64'(in_ready), 64'(0));
    cyc(1, 32'h77, 1, 0, 0, 1);
    cyc(1, 32'h78, 1, 0, 0, 0);
    repeat (3) cyc(0, '0, 1, 0, 0, 0);
    done = 1;
    @(negedge Clock); #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
